// File: rtl/spi_wait_timer.sv
// Programmable wait timer: counts enabled falling clock edges and pulses trigger at terminal count.
// Optional prescaler enabled by defining WAIT_TIMER_PRESCALE_EN.
module spi_wait_timer #(
    parameter int unsigned CNT_W      = 7,
    parameter int unsigned DEFAULT_TC = 30,
    parameter int unsigned PRESCALE   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mode,
    input  logic             load_tc,
    input  logic [CNT_W-1:0] tc_in,
    output logic             trigger,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_counter;
    logic [CNT_W-1:0] r_tc;
    logic             r_trigger;
    logic             r_done;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_counter_nxt;
    logic             w_trigger_nxt;
    logic             w_done_nxt;
    logic             w_tick;
    logic             w_terminal;

`ifdef WAIT_TIMER_PRESCALE_EN
    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] r_prescale;

    assign w_tick = (r_prescale == PS_W'(PRESCALE - 1));

    // Free-runs in IDLE and COUNT so the IDLE->COUNT move also waits for a tick.
    always_ff @(negedge clk) begin
        if (rst || !enable) begin
            r_prescale <= '0;
        end else if (r_state != HOLD) begin
            r_prescale <= w_tick ? '0 : r_prescale + 1'b1;
        end
    end
`else
    // Every edge is a tick; PRESCALE has no effect in this build.
    assign w_tick = (PRESCALE != 0) || 1'b1;
`endif

    assign w_terminal = (r_counter >= r_tc);

    always_comb begin
        w_state_nxt   = r_state;
        w_counter_nxt = r_counter;
        w_trigger_nxt = 1'b0;
        w_done_nxt    = r_done;

        if (!enable) begin
            w_state_nxt   = IDLE;
            w_counter_nxt = '0;
            w_done_nxt    = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_counter_nxt = '0;
                    w_done_nxt    = 1'b0;
                    if (w_tick) begin
                        if (r_tc == '0) begin
                            w_trigger_nxt = 1'b1;
                            if (mode) begin
                                w_done_nxt  = 1'b1;
                                w_state_nxt = HOLD;
                            end else begin
                                w_state_nxt = COUNT;
                            end
                        end else begin
                            w_state_nxt   = COUNT;
                            w_counter_nxt = CNT_W'(1);
                        end
                    end
                end
                COUNT: begin
                    if (w_tick) begin
                        if (w_terminal) begin
                            w_trigger_nxt = 1'b1;
                            if (mode) begin
                                w_done_nxt  = 1'b1;
                                w_state_nxt = HOLD;
                            end else begin
                                w_counter_nxt = '0;
                            end
                        end else begin
                            w_counter_nxt = r_counter + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    w_done_nxt = 1'b1;
                    if (!mode) begin
                        w_done_nxt    = 1'b0;
                        w_counter_nxt = '0;
                        w_state_nxt   = COUNT;
                    end
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_counter_nxt = '0;
                    w_done_nxt    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_counter <= '0;
            r_tc      <= CNT_W'(DEFAULT_TC);
            r_trigger <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_counter <= w_counter_nxt;
            r_trigger <= w_trigger_nxt;
            r_done    <= w_done_nxt;
            // Terminal decision above already used the old value.
            if (load_tc) begin
                r_tc <= tc_in;
            end
        end
    end

    assign trigger = r_trigger;
    assign done    = r_done;
    assign busy    = (r_state == COUNT);
    assign count   = r_counter;

endmodule

// File: tb/tb_spi_wait_timer.sv
// Directed bench for spi_wait_timer (default build): expected output words are queued
// as each step is driven and popped for comparison after the falling edge.
module tb_spi_wait_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       mode;
    logic       load_tc;
    logic [6:0] tc_in;
    logic       trigger;
    logic       done;
    logic       busy;
    logic [6:0] count;

    always #5 clk = ~clk;

    spi_wait_timer #(
        .CNT_W      (7),
        .DEFAULT_TC (30),
        .PRESCALE   (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .mode    (mode),
        .load_tc (load_tc),
        .tc_in   (tc_in),
        .trigger (trigger),
        .done    (done),
        .busy    (busy),
        .count   (count)
    );

    typedef struct {
        string      tag;
        logic [9:0] word;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Word layout: {trigger, done, busy, count}
    task automatic step(input string tag, input logic t, input logic d, input logic b,
                        input int c);
        exp_t e;
        exp_t got;
        logic [9:0] obs;
        e.tag  = tag;
        e.word = {t, d, b, 7'(c)};
        sb.push_back(e);
        @(negedge clk);
        #1;
        got = sb.pop_front();
        obs = {trigger, done, busy, count};
        n_cmp++;
        assert (obs === got.word)
        else begin
            n_bad++;
            $error("FAIL %s: observed trg=%b done=%b busy=%b cnt=%0d expected trg=%b done=%b busy=%b cnt=%0d",
                   got.tag, obs[9], obs[8], obs[7], obs[6:0],
                   got.word[9], got.word[8], got.word[7], got.word[6:0]);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 1'b0; load_tc = 1'b0; tc_in = '0;
        step("reset0", 0, 0, 0, 0);
        step("reset1", 0, 0, 0, 0);

        // Periodic with default TC=30: pulses at edges 31, 62, 93.
        rst = 1'b0; enable = 1'b1;
        for (int e = 1; e <= 93; e++) step("periodic_dflt", (e % 31) == 0, 0, 1, e % 31);
        enable = 1'b0;
        step("disable_idle", 0, 0, 0, 0);

        // One-shot with TC=5.
        load_tc = 1'b1; tc_in = 7'd5;
        step("load_idle", 0, 0, 0, 0);
        load_tc = 1'b0; mode = 1'b1; enable = 1'b1;
        for (int e = 1; e <= 5; e++) step("oneshot_cnt", 0, 0, 1, e);
        step("oneshot_fire", 1, 1, 0, 5);
        for (int e = 0; e < 20; e++) step("oneshot_hold", 0, 1, 0, 5);
        enable = 1'b0;
        step("oneshot_release", 0, 0, 0, 0);

        // Mid-run TC reduction 30 -> 10 at count 20.
        load_tc = 1'b1; tc_in = 7'd30; mode = 1'b0;
        step("load30", 0, 0, 0, 0);
        load_tc = 1'b0; enable = 1'b1;
        for (int e = 1; e <= 20; e++) step("pre_reduce", 0, 0, 1, e);
        load_tc = 1'b1; tc_in = 7'd10;
        step("reduce_edge", 0, 0, 1, 21);
        load_tc = 1'b0;
        step("reduce_fire", 1, 0, 1, 0);
        for (int k = 1; k <= 22; k++) begin
            mode = (k <= 5);
            step("period11", (k % 11) == 0, 0, 1, k % 11);
        end
        mode = 1'b0;

        // Enable dropped on what would be the terminal edge.
        for (int e = 1; e <= 10; e++) step("pre_drop", 0, 0, 1, e);
        enable = 1'b0;
        step("drop_on_term", 0, 0, 0, 0);

        // TC=0 periodic holds trigger high.
        load_tc = 1'b1; tc_in = 7'd0;
        step("load0", 0, 0, 0, 0);
        load_tc = 1'b0; enable = 1'b1;
        for (int e = 0; e < 5; e++) step("tc0_held", 1, 0, 1, 0);
        enable = 1'b0;
        step("tc0_off", 0, 0, 0, 0);

        // TC=127: period 128, no overflow.
        load_tc = 1'b1; tc_in = 7'd127;
        step("load127", 0, 0, 0, 0);
        load_tc = 1'b0; enable = 1'b1;
        for (int e = 1; e <= 256; e++) step("tc127", (e % 128) == 0, 0, 1, e % 128);

        // Reset mid-count restores DEFAULT_TC and restarts at 1.
        enable = 1'b0;
        step("pre_rst_idle", 0, 0, 0, 0);
        enable = 1'b1;
        for (int e = 1; e <= 17; e++) step("pre_rst_cnt", 0, 0, 1, e);
        rst = 1'b1;
        step("rst_mid", 0, 0, 0, 0);
        rst = 1'b0;
        for (int e = 1; e <= 31; e++) step("post_rst", (e % 31) == 0, 0, 1, e % 31);

        // rst beats load_tc on the same edge.
        rst = 1'b1; load_tc = 1'b1; tc_in = 7'd5;
        step("rst_vs_load", 0, 0, 0, 0);
        rst = 1'b0; load_tc = 1'b0;
        for (int e = 1; e <= 31; e++) step("rst_won", (e % 31) == 0, 0, 1, e % 31);

        // HOLD exits to COUNT when mode returns to 0.
        enable = 1'b0; load_tc = 1'b1; tc_in = 7'd3;
        step("load3", 0, 0, 0, 0);
        load_tc = 1'b0; mode = 1'b1; enable = 1'b1;
        for (int e = 1; e <= 3; e++) step("os3_cnt", 0, 0, 1, e);
        step("os3_fire", 1, 1, 0, 3);
        step("os3_hold", 0, 1, 0, 3);
        mode = 1'b0;
        step("hold_exit", 0, 0, 1, 0);
        for (int e = 1; e <= 3; e++) step("after_exit", 0, 0, 1, e);
        step("after_exit_fire", 1, 0, 1, 0);

        // load_tc on a terminal edge does not change that edge's decision.
        for (int e = 1; e <= 3; e++) step("pre_term_load", 0, 0, 1, e);
        load_tc = 1'b1; tc_in = 7'd10;
        step("term_load_fire", 1, 0, 1, 0);
        load_tc = 1'b0;
        for (int k = 1; k <= 11; k++) step("after_term_load", (k % 11) == 0, 0, 1, k % 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_wait_timer.md
# spi_wait_timer

Programmable wait timer for the SPI and sensor-control path. While `enable` is high it counts falling edges of `clk` and emits a one-cycle `trigger` pulse when the count reaches a run-time terminal count. It supports periodic and one-shot modes, a loadable terminal count, a synchronous reset and an optional prescaler. SPI transaction sequencers instantiate it to space out CS/SCLK phases and inter-frame gaps.

## Interface
- `CNT_W`, default 7: counter and terminal-count width.
- `DEFAULT_TC`, default 30: reset value of the terminal-count register; must be < 2^CNT_W.
- `PRESCALE`, default 4: clock division ratio, ≥ 2; used only when `WAIT_TIMER_PRESCALE_EN` is defined.

Ports:
- `clk` in 1: single clock; all registers update on its falling edge.
- `rst` in 1: synchronous, active-high reset, sampled on the falling edge of `clk`.
- `enable` in 1: run request; low = idle and cleared.
- `mode` in 1: 0 = periodic, 1 = one-shot.
- `load_tc` in 1: load `tc_in` into the terminal-count register this edge.
- `tc_in` in CNT_W: new terminal count.
- `trigger` out 1: registered one-cycle pulse at terminal count.
- `done` out 1: one-shot completed; held until `enable` falls.
- `busy` out 1: high in COUNT state.
- `count` out CNT_W: current counter value.

## Operation
- Registers: `counter`, `tc_reg`, `state`, `trigger`, `done`.
- Reset values: `counter`=0, `tc_reg`=DEFAULT_TC, `state`=IDLE, `trigger`=0, `done`=0, `busy`=0, prescaler=0.
- `rst` overrides every other input.
- `load_tc` is accepted in any state: `tc_reg <= tc_in` on that edge. The new value takes effect for comparisons from the next edge.
- Terminal test is `counter >= tc_reg`, so lowering `tc_reg` below the current count fires a terminal on the next active edge. No wrap past 2^CNT_W−1 is possible.
- State machine (each arrow is taken on an edge):
  - IDLE: `counter`=0, `trigger`=0, `done`=0. If `enable`=1, go to COUNT and set `counter` to 1. If `tc_reg`=0, take the terminal action instead.
  - COUNT, non-terminal: `counter`+1, `trigger`=0.
  - COUNT, terminal, `mode`=0: `counter`=0, `trigger`=1, stay in COUNT.
  - COUNT, terminal, `mode`=1: `trigger`=1, `done`=1, go to HOLD with `counter` frozen.
  - HOLD: `trigger`=0, `done`=1, `counter` holds. If `mode` changes to 0, clear `done` and `counter` and go to COUNT.
  - Any state with `enable`=0: go to IDLE with all outputs cleared on that edge.
- `tc_reg`=0 in periodic mode: `trigger` is held continuously high while enabled.
- `mode` is sampled every edge. Switching from 1 to 0 in COUNT simply continues the count.

## Timing
- Period in periodic mode is `tc_reg`+1 enabled edges.
- The first `trigger` is high after the (`tc_reg`+1)-th falling edge with `enable` high. With the default, that is the 31st edge, and the pulse lasts exactly one cycle.
- `count` equals the number of enabled edges since the last terminal.
- If `enable` falls on the same edge as a terminal, `enable` wins: IDLE, no `trigger`.
- If `rst` and `load_tc` occur on the same edge, `rst` wins: `tc_reg`=DEFAULT_TC.
- A `load_tc` on a terminal edge does not affect that edge's terminal decision.
- Outputs are glitch-free registers; there are no combinational paths from inputs to outputs.

## Configuration
- `WAIT_TIMER_PRESCALE_EN` defined:
  - A modulo-PRESCALE prescaler (width `$clog2(PRESCALE)`) runs while the block is in COUNT or on the IDLE→COUNT edge.
  - The counter, terminal test and state transitions advance only on prescaler tick edges, where the prescaler equals PRESCALE−1.
  - Period is (`tc_reg`+1)·PRESCALE edges. `trigger` is still one `clk` cycle wide.
  - `enable`=0 or `rst` clears the prescaler.
- Undefined: no prescaler logic is generated, every edge is a tick, and `PRESCALE` is ignored.

## Test plan
- Reset, default TC: `rst` for 2 edges, then `enable`=1, `mode`=0 → `trigger` pulses on edges 31, 62 and 93, one cycle each; `count` sequence is 1..30, 0.
- Load and one-shot: `load_tc` with `tc_in`=5 while idle, `mode`=1, `enable`=1 → single `trigger` at edge 6, then `done`=1 and `count`=5 held for 20 edges; `enable`=0 → `done`=0 and `count`=0 next edge.
- Mid-run TC reduction: TC=30, at `count`=20 load `tc_in`=10 → `trigger` on the next edge, `count`=0, then period 11.
- Boundaries: TC=0 periodic → `trigger` held high; TC=127 with CNT_W=7 → period 128, no overflow; `enable` dropped on a terminal edge → no `trigger`.
- Reset mid-count: `rst` at `count`=17 → all outputs 0 and `tc_reg`=30 next edge; with `enable` still high the count restarts at 1.
- With `WAIT_TIMER_PRESCALE_EN`, PRESCALE=4, TC=3 → `trigger` every 16 edges, first at edge 16, one cycle wide.
